// File: rtl/mips_pkg.sv
// Shared pipeline definitions: MEM-stage FSM encoding and the default access timeout.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for an outstanding data-memory access; tc flags the last allowed WAIT cycle.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    // clear has priority so the count restarts from zero on every exit from WAIT
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: converts MemRead/MemWrite into a req/ack memory transaction and stalls the pipe meanwhile.
module mem_stage_ctrl
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_mem_memread,
    input  logic              ex_mem_memwrite,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [DATA_W-1:0] ex_mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              wb_bubble,
    output logic [DATA_W-1:0] rdata_out,
    output logic              bus_err
);

    mem_state_e state;
    logic       req_in;
    logic       in_wait;
    logic       tc;

    assign req_in  = ex_mem_memread || ex_mem_memwrite;
    assign in_wait = (state == WAIT);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (!in_wait || mem_ack),
        .en    (in_wait),
        .tc    (tc)
    );

    // Hold upstream from the moment the op is seen in IDLE; DONE releases so EX/MEM and MEM/WB advance
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            stall = (state == IDLE && req_in) || in_wait;
        end
    end

    assign wb_bubble = stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_out <= '0;
            bus_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_in) begin
                        mem_req   <= 1'b1;
                        mem_we    <= ex_mem_memwrite;
                        mem_addr  <= ex_mem_addr;
                        mem_wdata <= ex_mem_wdata;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            rdata_out <= mem_rdata;
                        end
                        state <= DONE;
                    end else if (tc) begin
                        mem_req   <= 1'b0;
                        bus_err   <= 1'b1;
                        rdata_out <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
